// File: rtl/alu_share_ctrl.sv
// Round-robin controller sharing one combinational ALU among NREQ requesters.
// One operation in flight: accept (IDLE) -> drive ALU (EXEC) -> return result (RESP).
module alu_share_ctrl #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*OPW-1:0]   req_op,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [OPW-1:0]        alu_cmd,
  output logic [WIDTH-1:0]      alu_val1,
  output logic [WIDTH-1:0]      alu_val2,
  input  logic [WIDTH-1:0]      alu_out,
  input  logic                  alu_zero,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]      resp_data,
  output logic                  resp_zero,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   rr_ptr, grant, gnt_q;
  logic            found;
  logic            accept;
  int              idx;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = IW'(idx);
      end
    end
  end

  // Both handshakes complete on a rising edge where valid and ready are high
  // together; ready never depends on anything but state, arbitration and rst_n.
  assign accept     = (state == IDLE) && found;
  assign req_ready  = (rst_n && accept) ? (NREQ'(1) << grant) : '0;
  assign resp_valid = (rst_n && state == RESP) ? (NREQ'(1) << gnt_q) : '0;
  assign busy       = (state != IDLE);
  assign dbg_state  = state;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (resp_ready[gnt_q]) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // ALU operand registers hold their last values outside EXEC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      gnt_q     <= '0;
      alu_cmd   <= '0;
      alu_val1  <= '0;
      alu_val2  <= '0;
      resp_data <= '0;
      resp_zero <= 1'b0;
    end else begin
      if (accept) begin
        gnt_q    <= grant;
        alu_cmd  <= req_op[int'(grant)*OPW +: OPW];
        alu_val1 <= req_a[int'(grant)*WIDTH +: WIDTH];
        alu_val2 <= req_b[int'(grant)*WIDTH +: WIDTH];
        rr_ptr   <= (grant == IW'(NREQ-1)) ? '0 : grant + IW'(1);
      end
      if (state == EXEC) begin
        resp_data <= alu_out;
        resp_zero <= alu_zero;
      end
    end
  end

endmodule
